alu_exec_fsm: RTL and testbench
===============================

Name: alu_exec_fsm

Overview:
Parametrised successor to the single-operand ALU-immediate control FSM. It sequences one ALU instruction over the shared data bus. It supports two modes: register-immediate (Rd = Rd op imm) and register-register (Rd = Rd op Rs). The register count, bus width, immediate width and opcode width are configurable. It also adds the following:
- a busy/done handshake
- sign/zero immediate extension
- write-back suppression for compare-class opcodes
- illegal-register detection

It sits between the instruction decoder and the register file / ALU enables.

Parameters:
DATA_W, 16, bus and immediate-extension width.
NUM_REGS, 5, number of addressable bus registers (index 0..NUM_REGS-1).
SEL_W, 3, register-select width; must satisfy 2**SEL_W >= NUM_REGS.
IMM_W, 6, immediate field width; must be <= DATA_W.
OP_W, 3, ALU opcode width.
NOWB_MASK, 8'h80, 2**OP_W-bit mask; bit k=1 means opcode k does no register write-back (default: opcode 7 = compare).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request; accepted only in IDLE.
mode  in  1  0 = register-immediate, 1 = register-register.
imm_signed  in  1  1 = sign-extend imm, 0 = zero-extend.
op_code  in  OP_W  ALU operation.
rd_sel  in  SEL_W  destination / first-source register.
rs_sel  in  SEL_W  second-source register (mode=1 only).
imm  in  IMM_W  immediate operand (mode=0 only).
reg_read  out  NUM_REGS  one-hot register bus-drive enables.
reg_write  out  NUM_REGS  one-hot register load enables.
alu_op  out  OP_W  ALU operation select; 0 outside EVAL.
alu_write_in1  out  1  ALU latches the bus into IN1.
alu_write_in2  out  1  ALU latches the bus into IN2.
alu_out_en  out  1  ALU evaluates.
alu_read  out  1  ALU drives its result onto the bus.
out_to_bus  out  DATA_W  extended immediate when driving, else all Z.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle completion pulse.
err  out  1  one-cycle pulse with done when the instruction aborted.

Behaviour:
- Reset:
  - Synchronous. On the first rising edge with reset=1 the state becomes IDLE.
  - All outputs are 0, except out_to_bus, which is Z.
  - Reset mid-instruction aborts it with no done and no err.
  - Reset has priority over start.
- Operand latching:
  - On acceptance (state IDLE and start=1), latch mode, imm_signed, op_code, rd_sel, rs_sel and imm.
  - Input changes after acceptance are ignored.
- Outputs:
  - All outputs are Moore-decoded from the present state and the latched operands.
  - In any state, every enable not listed for that state is 0.
- States and transitions:
  - IDLE:
    - start=1 with rd_sel < NUM_REGS, and (mode=0 or rs_sel < NUM_REGS): go to IN1.
    - start=1 with an illegal index: go to ABORT.
    - Otherwise stay in IDLE.
  - IN1: reg_read[rd]=1, alu_write_in1=1. Next state IN2.
  - IN2:
    - mode=0: out_to_bus = extended imm, alu_write_in2=1.
    - mode=1: reg_read[rs]=1, alu_write_in2=1, out_to_bus=Z.
    - Next state EVAL.
  - EVAL: alu_out_en=1, alu_op=op. Next state DONE if NOWB_MASK[op]=1, else OUT.
  - OUT: alu_read=1, reg_write[rd]=1. Next state DONE.
  - DONE: done=1. Next state IDLE.
  - ABORT: done=1, err=1. Next state IDLE. No register or ALU enable is asserted.
- Latency (start accepted at cycle N):
  - Write-back op: done at N+5.
  - No-write-back op: done at N+4.
  - Abort: done at N+1.
  - Earliest next acceptance is the cycle after done.
- start while busy is ignored. It is not queued.
- start=1 held continuously gives back-to-back instructions with exactly one IDLE cycle between them.
- Immediate extension:
  - IMM_W=DATA_W: pass-through.
  - Sign extension replicates imm[IMM_W-1].
  - Zero extension pads with 0.
- Bus ownership:
  - out_to_bus is non-Z only in IN2 with mode=0.
  - At most one reg_read bit is set in any cycle.
  - reg_read and alu_read are never both set in the same cycle.
- rd=rs in mode=1 is legal: the same register is read in IN1 and in IN2.
- An undefined state encoding recovers to IDLE on the next edge, with outputs as in IDLE.

Test Plan:
1. reset=1 for 2 cycles mid-EVAL -> next cycle state IDLE, all enables 0, out_to_bus=Z, busy=0, no done.
2. mode=0, op=2, rd=1, imm=6'b111110, imm_signed=1 -> IN2 out_to_bus=16'hFFFE; imm_signed=0 -> 16'h003E; reg_write=5'b00010 at N+4; done at N+5.
3. mode=1, op=1, rd=3, rs=0 -> reg_read=5'b01000 at N+1, 5'b00001 at N+2 with out_to_bus=Z; reg_write=5'b01000 at N+4.
4. op=7 (masked), rd=2 -> EVAL at N+3, done at N+4; reg_write and alu_read never asserted.
5. rd=5 (NUM_REGS=5), or mode=1 with rs=6 -> done=1 and err=1 at N+1; all enables 0 throughout.
6. start held high for 12 cycles with write-back ops -> done at N+5 and N+11; start pulses in busy cycles are ignored; operands changed after acceptance have no effect.

Source files
------------

// File: rtl/alu_exec_fsm_if.sv
// ---------------------------------------------------------------------------
// alu_exec_fsm_if
//   Groups the decoder-side request fields and the register-file / ALU
//   enables of one ALU-instruction sequencer.
//
//   master : instruction decoder side (drives the request, observes status)
//   slave  : sequencer side (alu_exec_fsm)
//
//   Request : start, mode, imm_signed, op_code, rd_sel, rs_sel, imm
//   Enables : reg_read, reg_write, alu_op, alu_write_in1, alu_write_in2,
//             alu_out_en, alu_read
//   Status  : busy, done, err
// ---------------------------------------------------------------------------
interface alu_exec_fsm_if #(
  parameter int NUM_REGS = 5,
  parameter int SEL_W    = 3,
  parameter int IMM_W    = 6,
  parameter int OP_W     = 3
);
  logic                start;
  logic                mode;
  logic                imm_signed;
  logic [OP_W-1:0]     op_code;
  logic [SEL_W-1:0]    rd_sel;
  logic [SEL_W-1:0]    rs_sel;
  logic [IMM_W-1:0]    imm;

  logic [NUM_REGS-1:0] reg_read;
  logic [NUM_REGS-1:0] reg_write;
  logic [OP_W-1:0]     alu_op;
  logic                alu_write_in1;
  logic                alu_write_in2;
  logic                alu_out_en;
  logic                alu_read;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, mode, imm_signed, op_code, rd_sel, rs_sel, imm,
    input  reg_read, reg_write, alu_op, alu_write_in1, alu_write_in2,
           alu_out_en, alu_read, busy, done, err
  );

  modport slave (
    input  start, mode, imm_signed, op_code, rd_sel, rs_sel, imm,
    output reg_read, reg_write, alu_op, alu_write_in1, alu_write_in2,
           alu_out_en, alu_read, busy, done, err
  );
endinterface

// File: rtl/alu_exec_fsm.sv
// ---------------------------------------------------------------------------
// alu_exec_fsm
//   Sequences one ALU instruction over a shared data bus, either
//   Rd = Rd op imm (mode 0) or Rd = Rd op Rs (mode 1).
//
//   Sequence: IDLE -> IN1 -> IN2 -> EVAL -> [OUT] -> DONE -> IDLE
//             IDLE -> ABORT -> IDLE when a register index is out of range.
//   OUT is skipped for opcodes flagged in NOWB_MASK (compare-class ops).
//
//   Ports:
//     clk        : system clock, rising edge
//     reset      : synchronous, active-high
//     bus        : request fields, register / ALU enables, busy/done/err
//     out_to_bus : extended immediate while driving (IN2, mode 0), else Z
//
//   All outputs are registered: each transition also loads the output
//   values belonging to the state being entered, so they are Moore outputs
//   of the present state without any decode glitches.
// ---------------------------------------------------------------------------
module alu_exec_fsm #(
  parameter int                      DATA_W    = 16,
  parameter int                      NUM_REGS  = 5,
  parameter int                      SEL_W     = 3,
  parameter int                      IMM_W     = 6,
  parameter int                      OP_W      = 3,
  parameter logic [(1<<OP_W)-1:0]    NOWB_MASK = 8'h80
) (
  input  logic                clk,
  input  logic                reset,
  alu_exec_fsm_if.slave       bus,
  output wire  [DATA_W-1:0]   out_to_bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IN1   = 3'd1,
    S_IN2   = 3'd2,
    S_EVAL  = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5,
    S_ABORT = 3'd6
  } state_t;

  state_t              state_reg;

  // Operands captured on acceptance; the request inputs are ignored after.
  logic                mode_reg;
  logic                imm_signed_reg;
  logic [OP_W-1:0]     op_reg;
  logic [SEL_W-1:0]    rd_reg;
  logic [SEL_W-1:0]    rs_reg;
  logic [IMM_W-1:0]    imm_reg;

  // Registered outputs
  logic [NUM_REGS-1:0] reg_read_reg;
  logic [NUM_REGS-1:0] reg_write_reg;
  logic [OP_W-1:0]     alu_op_reg;
  logic                alu_write_in1_reg;
  logic                alu_write_in2_reg;
  logic                alu_out_en_reg;
  logic                alu_read_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                err_reg;
  logic                drive_reg;

  // One-hot decodes. The incoming rd is needed directly because the IN1
  // enables are loaded on the same edge that accepts the request.
  logic [NUM_REGS-1:0] rd_hot_in;
  logic [NUM_REGS-1:0] rd_hot;
  logic [NUM_REGS-1:0] rs_hot;
  logic [DATA_W-1:0]   imm_ext;
  logic                legal_in;

  genvar gi;

  for (gi = 0; gi < NUM_REGS; gi++) begin : g_hot
    assign rd_hot_in[gi] = (bus.rd_sel == SEL_W'(gi));
    assign rd_hot[gi]    = (rd_reg == SEL_W'(gi));
    assign rs_hot[gi]    = (rs_reg == SEL_W'(gi));
  end

  // Immediate extension: field bits pass through, upper bits take the sign
  // bit when signed and 0 otherwise. With IMM_W == DATA_W there are no pad
  // bits and the field passes through unchanged.
  for (gi = 0; gi < DATA_W; gi++) begin : g_ext
    if (gi < IMM_W) begin : g_field
      assign imm_ext[gi] = imm_reg[gi];
    end else begin : g_pad
      assign imm_ext[gi] = imm_signed_reg & imm_reg[IMM_W-1];
    end
  end

  // rs only matters for register-register instructions.
  assign legal_in = (int'(bus.rd_sel) < NUM_REGS) &&
                    (!bus.mode || (int'(bus.rs_sel) < NUM_REGS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= S_IDLE;
      mode_reg          <= 1'b0;
      imm_signed_reg    <= 1'b0;
      op_reg            <= '0;
      rd_reg            <= '0;
      rs_reg            <= '0;
      imm_reg           <= '0;
      reg_read_reg      <= '0;
      reg_write_reg     <= '0;
      alu_op_reg        <= '0;
      alu_write_in1_reg <= 1'b0;
      alu_write_in2_reg <= 1'b0;
      alu_out_en_reg    <= 1'b0;
      alu_read_reg      <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      err_reg           <= 1'b0;
      drive_reg         <= 1'b0;
    end else begin
      // Every enable defaults to 0; each branch raises only what the
      // state being entered needs. busy defaults high and is cleared on
      // the paths that land in IDLE.
      reg_read_reg      <= '0;
      reg_write_reg     <= '0;
      alu_op_reg        <= '0;
      alu_write_in1_reg <= 1'b0;
      alu_write_in2_reg <= 1'b0;
      alu_out_en_reg    <= 1'b0;
      alu_read_reg      <= 1'b0;
      busy_reg          <= 1'b1;
      done_reg          <= 1'b0;
      err_reg           <= 1'b0;
      drive_reg         <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            mode_reg       <= bus.mode;
            imm_signed_reg <= bus.imm_signed;
            op_reg         <= bus.op_code;
            rd_reg         <= bus.rd_sel;
            rs_reg         <= bus.rs_sel;
            imm_reg        <= bus.imm;
            if (legal_in) begin
              state_reg         <= S_IN1;
              reg_read_reg      <= rd_hot_in;
              alu_write_in1_reg <= 1'b1;
            end else begin
              state_reg <= S_ABORT;
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
            end
          end else begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        end

        S_IN1: begin
          state_reg         <= S_IN2;
          alu_write_in2_reg <= 1'b1;
          if (mode_reg) begin
            reg_read_reg <= rs_hot;
          end else begin
            drive_reg <= 1'b1;
          end
        end

        S_IN2: begin
          state_reg      <= S_EVAL;
          alu_out_en_reg <= 1'b1;
          alu_op_reg     <= op_reg;
        end

        S_EVAL: begin
          if (NOWB_MASK[op_reg]) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end else begin
            state_reg     <= S_OUT;
            alu_read_reg  <= 1'b1;
            reg_write_reg <= rd_hot;
          end
        end

        S_OUT: begin
          state_reg <= S_DONE;
          done_reg  <= 1'b1;
        end

        S_DONE, S_ABORT: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end

        // Unused encoding: fall back to IDLE with IDLE outputs.
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reg_read      = reg_read_reg;
  assign bus.reg_write     = reg_write_reg;
  assign bus.alu_op        = alu_op_reg;
  assign bus.alu_write_in1 = alu_write_in1_reg;
  assign bus.alu_write_in2 = alu_write_in2_reg;
  assign bus.alu_out_en    = alu_out_en_reg;
  assign bus.alu_read      = alu_read_reg;
  assign bus.busy          = busy_reg;
  assign bus.done          = done_reg;
  assign bus.err           = err_reg;

  assign out_to_bus = drive_reg ? imm_ext : {DATA_W{1'bz}};

endmodule

// File: tb/tb_alu_exec_fsm.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_fsm
//   Directed cases followed by randomized traffic. The reference model turns
//   each accepted instruction into the list of per-cycle output patterns the
//   instruction must produce; every cycle the DUT outputs are compared with
//   the next pattern (or the idle pattern when nothing is in flight).
// ---------------------------------------------------------------------------
module tb_alu_exec_fsm;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 5;
  localparam int SEL_W    = 3;
  localparam int IMM_W    = 6;
  localparam int OP_W     = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  wire [DATA_W-1:0] out_to_bus;

  alu_exec_fsm_if #(
    .NUM_REGS(NUM_REGS), .SEL_W(SEL_W), .IMM_W(IMM_W), .OP_W(OP_W)
  ) bus_if ();

  alu_exec_fsm #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W),
    .IMM_W(IMM_W), .OP_W(OP_W), .NOWB_MASK(8'h80)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if),
    .out_to_bus(out_to_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        idle;
    logic [4:0]  rr;
    logic [4:0]  rw;
    logic [2:0]  op;
    logic        wi1, wi2, oen, aread, busy, done, err;
    logic [15:0] bus;
  } exp_t;

  exp_t sched[$];
  logic cur_idle = 1'b1;
  int   cycle = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   txn_id = 0;
  int   accept_cycle = 0;
  int   lat_exp = 0;
  logic lat_pending = 1'b0;
  logic t_mode, t_sgn;
  logic [2:0] t_op, t_rd, t_rs;
  logic [5:0] t_imm;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want)
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cycle, got, want);
    else
      n_pass++;
  endtask

  function automatic exp_t busy_rec();
    exp_t e;
    e.idle = 1'b0; e.rr = '0; e.rw = '0; e.op = '0;
    e.wi1 = 1'b0; e.wi2 = 1'b0; e.oen = 1'b0; e.aread = 1'b0;
    e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0;
    e.bus = 16'bz;
    return e;
  endfunction

  function automatic exp_t idle_rec();
    exp_t e;
    e = busy_rec();
    e.idle = 1'b1;
    e.busy = 1'b0;
    return e;
  endfunction

  // Expected behaviour of one accepted instruction, cycle by cycle.
  task automatic push_txn(input logic m, input logic sg, input logic [2:0] op,
                          input logic [2:0] rd, input logic [2:0] rs, input logic [5:0] im);
    exp_t e;
    logic legal;
    logic [15:0] ext;
    legal = (rd < 3'(NUM_REGS)) && (!m || rs < 3'(NUM_REGS));
    ext = (sg && im >= 6'd32) ? 16'(int'(im) - 64) : 16'(im);
    txn_id++;
    accept_cycle = cycle - 1;
    lat_pending = 1'b1;
    t_mode = m; t_sgn = sg; t_op = op; t_rd = rd; t_rs = rs; t_imm = im;
    if (!legal) begin
      e = busy_rec(); e.done = 1'b1; e.err = 1'b1; sched.push_back(e);
      lat_exp = 1;
    end else begin
      e = busy_rec(); e.rr = 5'(1 << rd); e.wi1 = 1'b1; sched.push_back(e);
      e = busy_rec(); e.wi2 = 1'b1;
      if (m) e.rr = 5'(1 << rs); else e.bus = ext;
      sched.push_back(e);
      e = busy_rec(); e.oen = 1'b1; e.op = op; sched.push_back(e);
      if (op != 3'd7) begin
        e = busy_rec(); e.aread = 1'b1; e.rw = 5'(1 << rd); sched.push_back(e);
        lat_exp = 5;
      end else begin
        lat_exp = 4;
      end
      e = busy_rec(); e.done = 1'b1; sched.push_back(e);
    end
  endtask

  task automatic drive(input logic s, input logic m, input logic sg, input logic [2:0] op,
                       input logic [2:0] rd, input logic [2:0] rs, input logic [5:0] im);
    bus_if.start = s; bus_if.mode = m; bus_if.imm_signed = sg;
    bus_if.op_code = op; bus_if.rd_sel = rd; bus_if.rs_sel = rs; bus_if.imm = im;
  endtask

  // One clock edge: update the model with what the DUT saw, then compare.
  task automatic step();
    exp_t e;
    logic acc, r;
    logic c_mode, c_sgn;
    logic [2:0] c_op, c_rd, c_rs;
    logic [5:0] c_imm;
    r = reset;
    acc = !r && cur_idle && bus_if.start;
    c_mode = bus_if.mode; c_sgn = bus_if.imm_signed; c_op = bus_if.op_code;
    c_rd = bus_if.rd_sel; c_rs = bus_if.rs_sel; c_imm = bus_if.imm;
    @(posedge clk);
    #1;
    cycle++;
    if (r) begin
      sched.delete();
      lat_pending = 1'b0;
    end else if (acc) begin
      push_txn(c_mode, c_sgn, c_op, c_rd, c_rs, c_imm);
    end
    if (sched.size() > 0) e = sched.pop_front();
    else e = idle_rec();
    cur_idle = e.idle;

    check("reg_read", 32'(bus_if.reg_read), 32'(e.rr));
    check("reg_write", 32'(bus_if.reg_write), 32'(e.rw));
    check("alu_op", 32'(bus_if.alu_op), 32'(e.op));
    check("ctrl", {25'd0, bus_if.alu_write_in1, bus_if.alu_write_in2, bus_if.alu_out_en,
                   bus_if.alu_read, bus_if.busy, bus_if.done, bus_if.err},
                  {25'd0, e.wi1, e.wi2, e.oen, e.aread, e.busy, e.done, e.err});
    check("out_to_bus", {16'd0, out_to_bus}, {16'd0, e.bus});

    if (bus_if.done === 1'b1 && lat_pending) begin
      check("latency", 32'(cycle - accept_cycle), 32'(lat_exp));
      lat_pending = 1'b0;
    end
    if (e.done)
      $display("txn %0d: mode=%0d op=%0d rd=%0d rs=%0d imm=%h signed=%0d -> %s at cycle %0d",
               txn_id, t_mode, t_op, t_rd, t_rs, t_imm, t_sgn,
               e.err ? "abort" : "complete", cycle);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.start = 1'b0;
      step();
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 6'd0);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    idle_steps(2);

    // Reset for two cycles in the middle of EVAL aborts silently.
    drive(1'b1, 1'b0, 1'b0, 3'd3, 3'd4, 3'd0, 6'd9);
    step();
    idle_steps(2);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    idle_steps(3);

    // Register-immediate, sign- then zero-extended.
    drive(1'b1, 1'b0, 1'b1, 3'd2, 3'd1, 3'd0, 6'b111110); step(); idle_steps(7);
    drive(1'b1, 1'b0, 1'b0, 3'd2, 3'd1, 3'd0, 6'b111110); step(); idle_steps(7);
    // Register-register, and rd == rs.
    drive(1'b1, 1'b1, 1'b0, 3'd1, 3'd3, 3'd0, 6'd0); step(); idle_steps(7);
    drive(1'b1, 1'b1, 1'b0, 3'd4, 3'd2, 3'd2, 6'd0); step(); idle_steps(7);
    // Compare-class opcode skips write-back.
    drive(1'b1, 1'b0, 1'b0, 3'd7, 3'd2, 3'd0, 6'd5); step(); idle_steps(6);
    // Illegal indices abort; an out-of-range rs in mode 0 is irrelevant.
    drive(1'b1, 1'b0, 1'b0, 3'd1, 3'd5, 3'd0, 6'd1); step(); idle_steps(3);
    drive(1'b1, 1'b1, 1'b0, 3'd1, 3'd0, 3'd6, 6'd1); step(); idle_steps(3);
    drive(1'b1, 1'b0, 1'b0, 3'd1, 3'd0, 3'd7, 6'd1); step(); idle_steps(7);

    // start held high with write-back ops; operands change every cycle.
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 6)), 3'($urandom_range(0, 4)),
            3'($urandom_range(0, 4)), 6'($urandom));
      step();
    end
    idle_steps(7);

    // Randomized traffic, occasional reset.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom_range(0, 5)),
            3'($urandom_range(0, 6)), 6'($urandom));
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    idle_steps(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
